vram_arbiter: RTL

//  Shares one single-port VRAM between two requesters:
//   - the display fetch engine, which issues bursts of sequential reads;
//   - the Z80 I/O path, which issues single reads/writes.

---
 rtl/vram_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the display burst fetcher and the Z80 I/O path.
// Optional feature: define VRAM_ARB_FAIRNESS_EN to let a starved CPU steal one issue slot.
module vram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8,
    parameter int RD_LAT    = 2,
    parameter int MAX_WAIT  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_L,
    input  logic                                 disp_req,
    input  logic [ADDR_W-1:0]                    disp_base_addr,
    output logic                                 disp_ack,
    output logic [BURST_LEN-1:0][DATA_W-1:0]     disp_data,
    output logic                                 disp_done,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [ADDR_W-1:0]                    cpu_addr,
    input  logic [DATA_W-1:0]                    cpu_wdata,
    output logic                                 cpu_ack,
    output logic [DATA_W-1:0]                    cpu_rdata,
    output logic                                 cpu_rvalid,
    output logic [ADDR_W-1:0]                    vram_addr,
    output logic                                 vram_re,
    output logic                                 vram_we,
    output logic [DATA_W-1:0]                    vram_wdata,
    input  logic [DATA_W-1:0]                    vram_rdata,
    output logic                                 busy
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DISP = 1'b1
    } state_e;

    state_e                             state_q, state_d;
    logic [BEAT_W-1:0]                  beat_q, beat_d;
    logic [ADDR_W-1:0]                  base_q, base_d;
    logic                               disp_ack_q, disp_ack_d;
    logic                               disp_done_q, disp_done_d;
    logic [BURST_LEN-1:0][DATA_W-1:0]   disp_data_q, disp_data_d;
    logic                               cpu_ack_q, cpu_ack_d;
    logic                               cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0]                  cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0]                  cpu_wdata_q, cpu_wdata_d;
    logic [DATA_W-1:0]                  cpu_rdata_q, cpu_rdata_d;
    logic                               cpu_rvalid_q, cpu_rvalid_d;
    logic [ADDR_W-1:0]                  vram_addr_q, vram_addr_d;
    logic                               vram_re_q, vram_re_d;
    logic                               vram_we_q, vram_we_d;
    logic [DATA_W-1:0]                  vram_wdata_q, vram_wdata_d;
    logic [RD_LAT-1:0]                  tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0]                  tag_cpu_q, tag_cpu_d;
    logic [RD_LAT-1:0][BEAT_W-1:0]      tag_beat_q, tag_beat_d;
    logic                               busy_s;
    logic                               cpu_pri_s;

    assign busy_s = (state_q == ST_DISP) || ((tag_vld_q & ~tag_cpu_q) != '0);

`ifdef VRAM_ARB_FAIRNESS_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign cpu_pri_s = cpu_req && !cpu_ack_q && (wait_q == WAIT_W'(MAX_WAIT));

    // Starvation counter: cycles the CPU has waited, saturating at the threshold.
    always_comb begin
        wait_d = wait_q;
        if (cpu_ack_q) begin
            wait_d = '0;
        end else if (cpu_req && (wait_q != WAIT_W'(MAX_WAIT))) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign cpu_pri_s = 1'b0;
`endif

    // Issue the current slot's access, route returning read data, then arbitrate the next slot.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        disp_ack_d   = 1'b0;
        disp_done_d  = 1'b0;
        disp_data_d  = disp_data_q;
        cpu_ack_d    = 1'b0;
        cpu_we_d     = cpu_we_q;
        cpu_addr_d   = cpu_addr_q;
        cpu_wdata_d  = cpu_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        vram_addr_d  = vram_addr_q;
        vram_re_d    = 1'b0;
        vram_we_d    = 1'b0;
        vram_wdata_d = vram_wdata_q;
        tag_vld_d    = tag_vld_q;
        tag_cpu_d    = tag_cpu_q;
        tag_beat_d   = tag_beat_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_cpu_d[i]  = tag_cpu_q[i-1];
            tag_beat_d[i] = tag_beat_q[i-1];
        end
        tag_vld_d[0]  = 1'b0;
        tag_cpu_d[0]  = 1'b0;
        tag_beat_d[0] = '0;

        // A granted CPU access owns this slot; a burst in progress simply holds its beat.
        if (cpu_ack_q) begin
            vram_addr_d  = cpu_addr_q;
            vram_we_d    = cpu_we_q;
            vram_re_d    = !cpu_we_q;
            vram_wdata_d = cpu_wdata_q;
            tag_vld_d[0] = !cpu_we_q;
            tag_cpu_d[0] = 1'b1;
        end else if (state_q == ST_DISP) begin
            vram_addr_d   = base_q + ADDR_W'(beat_q);
            vram_re_d     = 1'b1;
            tag_vld_d[0]  = 1'b1;
            tag_beat_d[0] = beat_q;
            if (beat_q == LAST_BEAT) begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + BEAT_W'(1);
            end
        end else begin
            vram_wdata_d = vram_wdata_q;
        end

        if (tag_vld_q[RD_LAT-1]) begin
            if (tag_cpu_q[RD_LAT-1]) begin
                cpu_rdata_d  = vram_rdata;
                cpu_rvalid_d = 1'b1;
            end else begin
                disp_data_d[tag_beat_q[RD_LAT-1]] = vram_rdata;
                disp_done_d = (tag_beat_q[RD_LAT-1] == LAST_BEAT);
            end
        end else begin
            cpu_rvalid_d = 1'b0;
        end

        // The ack is registered, so it appears in the very cycle the granted slot issues.
        if (cpu_pri_s) begin
            cpu_ack_d   = 1'b1;
            cpu_we_d    = cpu_we;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end else if ((state_d == ST_IDLE) && disp_req && !busy_s) begin
            disp_ack_d = 1'b1;
            state_d    = ST_DISP;
            beat_d     = '0;
            base_d     = disp_base_addr;
        end else if ((state_d == ST_IDLE) && cpu_req && !cpu_ack_q) begin
            cpu_ack_d   = 1'b1;
            cpu_we_d    = cpu_we;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end else begin
            cpu_ack_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            disp_ack_q   <= 1'b0;
            disp_done_q  <= 1'b0;
            disp_data_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            vram_addr_q  <= '0;
            vram_re_q    <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= '0;
            tag_vld_q    <= '0;
            tag_cpu_q    <= '0;
            tag_beat_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            disp_ack_q   <= disp_ack_d;
            disp_done_q  <= disp_done_d;
            disp_data_q  <= disp_data_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_we_q     <= cpu_we_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_wdata_q  <= cpu_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vram_addr_q  <= vram_addr_d;
            vram_re_q    <= vram_re_d;
            vram_we_q    <= vram_we_d;
            vram_wdata_q <= vram_wdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_cpu_q    <= tag_cpu_d;
            tag_beat_q   <= tag_beat_d;
        end
    end

    assign disp_ack   = disp_ack_q;
    assign disp_done  = disp_done_q;
    assign disp_data  = disp_data_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign vram_addr  = vram_addr_q;
    assign vram_re    = vram_re_q;
    assign vram_we    = vram_we_q;
    assign vram_wdata = vram_wdata_q;
    assign busy       = busy_s;

endmodule
